prediction_argmax: RTL and testbench

- Downstream consumer of neural_network's Probability[9:0] vector.
- On a Start request it snapshots the 10 class scores and scans them sequentially, one class per cycle, to find the winning digit.
- Publishes the digit, its score, a confidence flag, and a stability flag for hex display and LED logic.
- Sits between neural_network and the hex_driver/LEDR path in the top level.

---
 rtl/nn_pkg.sv | 17 +
 rtl/argmax_step.sv | 25 ++
 rtl/prediction_argmax.sv | 183 ++++++++++++++++++
 tb/tb_prediction_argmax.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types for the classifier back end: score/digit typedefs, defaults,
// and the argmax scan FSM state encoding.
package nn_pkg;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int PROB_W_DEF      = 16;

    typedef logic [15:0] prob_t;
    typedef logic [3:0]  digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/argmax_step.sv
// One compare/update step of a running argmax: the candidate (idx, val)
// replaces the current leader only when strictly greater, so among equal
// scores the earliest index seen keeps the lead.
module argmax_step
    import nn_pkg::*;
#(
    parameter int PROB_W = PROB_W_DEF
) (
    input  digit_t            cur_idx,
    input  logic [PROB_W-1:0] cur_val,
    input  digit_t            idx,
    input  logic [PROB_W-1:0] val,
    output digit_t            new_idx,
    output logic [PROB_W-1:0] new_val,
    output logic              take
);

    // Strict unsigned compare; ties keep the current leader.
    always_comb begin
        take    = (val > cur_val);
        new_idx = take ? idx : cur_idx;
        new_val = take ? val : cur_val;
    end

endmodule

// File: rtl/prediction_argmax.sv
// Sequential argmax over the class scores. A Start in IDLE snapshots all
// scores, then one class is compared per cycle; the winner, its score and a
// confidence flag are published with a one-cycle Valid, and a stability
// flag reports whether the same digit won STABLE_COUNT passes in a row.
// Optional runner-up tracking (Digit2/Margin) is built when the macro
// ARGMAX_RUNNER_UP_EN is defined.
//
// Handshake: Start is a level request sampled only while IDLE; Busy is high
// from the cycle after acceptance until the cycle Valid pulses; Valid is a
// single-cycle strobe and the result outputs hold until the next Valid.
module prediction_argmax
    import nn_pkg::*;
#(
    parameter int                NUM_CLASSES  = NUM_CLASSES_DEF,
    parameter int                PROB_W       = PROB_W_DEF,
    parameter logic [PROB_W-1:0] CONF_THRESH  = 16'h4000,
    parameter int                STABLE_COUNT = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [PROB_W-1:0] Probability [NUM_CLASSES-1:0],
    output logic              Busy,
    output logic              Valid,
    output digit_t            Digit,
    output logic [PROB_W-1:0] MaxProb,
    output logic              Confident,
    output logic              Stable,
`ifdef ARGMAX_RUNNER_UP_EN
    output digit_t            Digit2,
    output logic [PROB_W-1:0] Margin,
`endif
    output argmax_state_t     dbg_state
);

    localparam digit_t     LAST_IDX = digit_t'(NUM_CLASSES - 1);
    localparam logic [3:0] STAB_MAX = 4'(STABLE_COUNT);

    argmax_state_t     state;
    digit_t            idx;
    digit_t            best_idx;
    logic [PROB_W-1:0] best_val;
    logic [PROB_W-1:0] snap [NUM_CLASSES-1:0];
    logic [3:0]        stab_cnt;
    digit_t            last_digit;

    digit_t            step_idx;
    logic [PROB_W-1:0] step_val;
    logic              step_take;
    logic [PROB_W-1:0] cur_score;
    logic [3:0]        stab_cnt_next;
    logic              conf_next;

    assign dbg_state = state;
    assign cur_score = snap[idx];

    argmax_step #(.PROB_W(PROB_W)) u_best (
        .cur_idx (best_idx),
        .cur_val (best_val),
        .idx     (idx),
        .val     (cur_score),
        .new_idx (step_idx),
        .new_val (step_val),
        .take    (step_take)
    );

`ifdef ARGMAX_RUNNER_UP_EN
    digit_t            second_idx;
    logic [PROB_W-1:0] second_val;
    digit_t            cand_idx;
    logic [PROB_W-1:0] cand_val;
    digit_t            second_idx_next;
    logic [PROB_W-1:0] second_val_next;
    logic              second_take;
    logic [PROB_W-1:0] margin_next;

    // A dethroned leader becomes the runner-up candidate; otherwise the new score is.
    always_comb begin
        cand_idx    = step_take ? best_idx : idx;
        cand_val    = step_take ? best_val : cur_score;
        margin_next = best_val - second_val;
    end

    argmax_step #(.PROB_W(PROB_W)) u_second (
        .cur_idx (second_idx),
        .cur_val (second_val),
        .idx     (cand_idx),
        .val     (cand_val),
        .new_idx (second_idx_next),
        .new_val (second_val_next),
        .take    (second_take)
    );
`endif

    // Result qualifiers computed from the final leader while in DONE.
    always_comb begin
        conf_next = (best_val >= CONF_THRESH);
`ifdef ARGMAX_RUNNER_UP_EN
        conf_next = conf_next && (margin_next >= (CONF_THRESH >> 2));
`endif
        if (best_idx == last_digit)
            stab_cnt_next = (stab_cnt >= STAB_MAX) ? STAB_MAX : stab_cnt + 4'd1;
        else
            stab_cnt_next = 4'd1;
    end

    // Score snapshot: pure datapath, loaded only when a pass is accepted.
    always_ff @(posedge Clk) begin
        if (state == IDLE && Start) begin
            for (int i = 0; i < NUM_CLASSES; i++)
                snap[i] <= Probability[i];
        end
    end

    // Scan FSM with registered outputs and stability tracking.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            best_idx   <= '0;
            best_val   <= '0;
            Busy       <= 1'b0;
            Valid      <= 1'b0;
            Digit      <= '0;
            MaxProb    <= '0;
            Confident  <= 1'b0;
            Stable     <= 1'b0;
            stab_cnt   <= '0;
            last_digit <= '0;
`ifdef ARGMAX_RUNNER_UP_EN
            second_idx <= '0;
            second_val <= '0;
            Digit2     <= '0;
            Margin     <= '0;
`endif
        end else begin
            Valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        best_idx <= '0;
                        best_val <= Probability[0];
                        idx      <= digit_t'(1);
                        Busy     <= 1'b1;
                        state    <= SCAN;
`ifdef ARGMAX_RUNNER_UP_EN
                        second_idx <= '0;
                        second_val <= '0;
`endif
                    end
                end
                SCAN: begin
                    best_idx <= step_idx;
                    best_val <= step_val;
`ifdef ARGMAX_RUNNER_UP_EN
                    second_idx <= second_idx_next;
                    second_val <= second_val_next;
`endif
                    idx <= idx + digit_t'(1);
                    if (idx == LAST_IDX)
                        state <= DONE;
                end
                DONE: begin
                    Digit      <= best_idx;
                    MaxProb    <= best_val;
                    Confident  <= conf_next;
                    Valid      <= 1'b1;
                    Busy       <= 1'b0;
                    last_digit <= best_idx;
                    stab_cnt   <= stab_cnt_next;
                    Stable     <= (stab_cnt_next >= STAB_MAX);
`ifdef ARGMAX_RUNNER_UP_EN
                    Digit2     <= second_idx;
                    Margin     <= margin_next;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prediction_argmax.sv
// Directed bench for prediction_argmax: reset values, latency/Busy window,
// ties, snapshot isolation, stability sequence and asynchronous abort.
module tb_prediction_argmax;
    import nn_pkg::*;

    localparam int N = 10;
    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  prob [N-1:0];
    logic          busy;
    logic          valid;
    digit_t        digit;
    logic [W-1:0]  max_prob;
    logic          confident;
    logic          stable;
    argmax_state_t dbg_state;
`ifdef ARGMAX_RUNNER_UP_EN
    digit_t        digit2;
    logic [W-1:0]  margin;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // expected result: {digit, max_prob, confident, stable}
    logic [21:0] exp_q[$];

    prediction_argmax dut (
        .Clk         (clk),
        .Reset_n     (rst_n),
        .Start       (start),
        .Probability (prob),
        .Busy        (busy),
        .Valid       (valid),
        .Digit       (digit),
        .MaxProb     (max_prob),
        .Confident   (confident),
        .Stable      (stable),
`ifdef ARGMAX_RUNNER_UP_EN
        .Digit2      (digit2),
        .Margin      (margin),
`endif
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".valid"},     32'(valid),     32'd0);
        check({tag, ".digit"},     32'(digit),     32'd0);
        check({tag, ".maxprob"},   32'(max_prob),  32'd0);
        check({tag, ".confident"}, 32'(confident), 32'd0);
        check({tag, ".stable"},    32'(stable),    32'd0);
        check({tag, ".state"},     32'(dbg_state), 32'(IDLE));
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) prob[i] = v;
    endtask

    // Raises Start in cycle 0 (before the next rising edge) and observes
    // 30 cycles at the falling edge. Optional events at given cycles:
    // poke Probability[5], a second Start pulse, an asynchronous reset.
    task automatic run_pass(input int poke_c, input int restart_c, input int rst_c,
                            output int lat, output int busy_n, output int valid_n);
        lat = -1; busy_n = 0; valid_n = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == poke_c) prob[5] = 16'hFFFF;
            if (c == restart_c) start = 1'b1;
            if (c == restart_c + 1) start = 1'b0;
            if (c == rst_c) begin
                rst_n = 1'b0;
                #1;
                check_outputs_zero("async_rst");
            end
            if (c == rst_c + 3) rst_n = 1'b1;
            if (busy) busy_n++;
            if (valid) begin
                valid_n++;
                if (lat < 0) lat = c;
            end
        end
    endtask

    // Scoreboard: queue the expected result, run one pass, compare.
    task automatic scored_pass(input string tag, input digit_t e_digit, input logic [W-1:0] e_max,
                               input logic e_conf, input logic e_stable);
        int lat, busy_n, valid_n;
        logic [21:0] e;
        exp_q.push_back({e_digit, e_max, e_conf, e_stable});
        run_pass(-1, -1, -1, lat, busy_n, valid_n);
        check({tag, ".latency"}, 32'(lat), 32'd11);
        check({tag, ".valids"},  32'(valid_n), 32'd1);
        e = exp_q.pop_front();
        check({tag, ".digit"},     32'(digit),     32'(e[21:18]));
        check({tag, ".maxprob"},   32'(max_prob),  32'(e[17:2]));
        check({tag, ".confident"}, 32'(confident), 32'(e[1]));
        check({tag, ".stable"},    32'(stable),    32'(e[0]));
    endtask

    initial begin
        int lat, busy_n, valid_n;
        rst_n = 1'b0;
        start = 1'b0;
        set_all('0);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // ascending scores, digit 9 wins, Busy window measured
        for (int i = 0; i < N; i++) prob[i] = 16'(100 * (i + 1));
        run_pass(-1, -1, -1, lat, busy_n, valid_n);
        check("ramp.latency", 32'(lat), 32'd11);
        check("ramp.busy",    32'(busy_n), 32'd10);
        check("ramp.valids",  32'(valid_n), 32'd1);
        check("ramp.digit",   32'(digit), 32'd9);
        check("ramp.maxprob", 32'(max_prob), 32'd1000);
        check("ramp.conf",    32'(confident), 32'd0);

        // single strong peak
        set_all(16'h0100);
        prob[3] = 16'h8000;
        scored_pass("peak3", 4'd3, 16'h8000, 1'b1, 1'b0);

        // tie between 2 and 7 -> lowest index
        set_all('0);
        prob[2] = 16'h5000;
        prob[7] = 16'h5000;
        scored_pass("tie", 4'd2, 16'h5000, 1'b1, 1'b0);

        // snapshot isolation plus ignored second Start while busy
        for (int i = 0; i < N; i++) prob[i] = 16'(100 * (i + 1));
        run_pass(4, 5, -1, lat, busy_n, valid_n);
        check("snap.valids",  32'(valid_n), 32'd1);
        check("snap.latency", 32'(lat), 32'd11);
        check("snap.digit",   32'(digit), 32'd9);
        check("snap.maxprob", 32'(max_prob), 32'd1000);

        // stability: digit 6 four times, then digit 1
        set_all(16'h0010);
        prob[6] = 16'h7000;
        scored_pass("stab1", 4'd6, 16'h7000, 1'b1, 1'b0);
        scored_pass("stab2", 4'd6, 16'h7000, 1'b1, 1'b0);
        scored_pass("stab3", 4'd6, 16'h7000, 1'b1, 1'b0);
        scored_pass("stab4", 4'd6, 16'h7000, 1'b1, 1'b1);
        set_all(16'h0010);
        prob[1] = 16'h3000;
        scored_pass("stab5", 4'd1, 16'h3000, 1'b0, 1'b0);

        // reset in cycle 6 of a scan: no Valid, outputs cleared
        set_all(16'h0020);
        prob[8] = 16'h9000;
        run_pass(-1, -1, 6, lat, busy_n, valid_n);
        check("abort.valids", 32'(valid_n), 32'd0);
        check("abort.digit",  32'(digit), 32'd0);
        check("abort.state",  32'(dbg_state), 32'(IDLE));

        // all-zero scores after reset: digit 0, nothing confident
        set_all('0);
        scored_pass("zeros", 4'd0, 16'h0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
